// File: rtl/uart_msg_tx_if.sv
// Message-side bundle of the UART message sender: request inputs plus line and status outputs.
// Latency: none, wires only.
// Backpressure: none; a request made while a message is in flight is queued one deep by the sender.
//   msg_data  8*MSG_LEN  message bytes, byte k in [8k+7:8k], byte 0 sent first
//   start / auto_en      one-cycle send request / periodic sending enable
//   UART_tx, busy, byte_idx, tx_done, msg_done   serial line and progress status
interface uart_msg_tx_if #(
    parameter int MSG_LEN = 9
);
    localparam int IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    logic [8*MSG_LEN-1:0] msg_data;
    logic                 start;
    logic                 auto_en;
    logic                 UART_tx;
    logic                 busy;
    logic [IW-1:0]        byte_idx;
    logic                 tx_done;
    logic                 msg_done;

    modport master (
        output msg_data, start, auto_en,
        input  UART_tx, busy, byte_idx, tx_done, msg_done
    );

    modport slave (
        input  msg_data, start, auto_en,
        output UART_tx, busy, byte_idx, tx_done, msg_done
    );
endinterface

// File: rtl/uart_msg_tx.sv
// Sends a MSG_LEN-byte message as UART frames (start, 8 data LSB first, optional parity, 1-2 stop).
// Latency: start bit appears the cycle after the request edge; every output is a flop.
// Backpressure: none; requests while busy set a one-deep pending flag launched right after msg_done.
//   clk, rst  clock and synchronous active-high reset
//   bus       uart_msg_tx_if.slave: msg_data/start/auto_en in, UART_tx/busy/byte_idx/tx_done/msg_done out
module uart_msg_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int MSG_LEN    = 9,
    parameter int PERIOD_CYC = 50000000,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_msg_tx_if.slave  bus
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CW       = $clog2(BAUD_DIV);
    localparam int IW       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int TW       = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;     // data bit number, or stop bit number in S_STOP
    logic [IW-1:0]        byte_idx_q, byte_idx_d;
    logic [8*MSG_LEN-1:0] msg_q, msg_d;
    logic                 pending_q, pending_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 mdone_q, mdone_d;

    logic       bit_end, timer_wrap, req, last_byte, cur_par, launch;
    logic [7:0] cur_byte;

    assign bit_end    = (bit_cnt_q == CW'(BAUD_DIV - 1));
    assign timer_wrap = (timer_q == TW'(PERIOD_CYC - 1));
    assign req        = bus.start | (bus.auto_en & timer_wrap);
    assign last_byte  = (byte_idx_q == IW'(MSG_LEN - 1));
    assign cur_byte   = msg_q[8*int'(byte_idx_q) +: 8];
    assign cur_par    = (^cur_byte) ^ (PARITY == 2);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_end ? '0 : bit_cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        msg_d      = msg_q;
        pending_d  = pending_q;
        launch     = 1'b0;

        if (!bus.auto_en || timer_wrap)
            timer_d = '0;
        else
            timer_d = timer_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                launch    = req;
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end)
                    state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                        bit_idx_d = '0;
                        if (last_byte) begin
                            byte_idx_d = '0;
                            // Chain straight into the next message with no idle cycle.
                            if (pending_q || req)
                                launch = 1'b1;
                            else
                                state_d = S_IDLE;
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                            state_d    = S_START;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && req)
            pending_d = 1'b1;

        // A launch consumes any pending request; extra requests have already collapsed into it.
        if (launch) begin
            state_d    = S_START;
            bit_idx_d  = '0;
            byte_idx_d = '0;
            msg_d      = bus.msg_data;
            pending_d  = 1'b0;
        end

        // Outputs are computed from next-state so the pin and pulses come straight from flops.
        done_d  = (state_d == S_STOP) && (bit_idx_d == 3'(STOP_BITS - 1)) &&
                  (bit_cnt_d == CW'(BAUD_DIV - 1));
        mdone_d = done_d && (byte_idx_d == IW'(MSG_LEN - 1));
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = cur_byte[bit_idx_d];
            S_PARITY: tx_d = cur_par;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            pending_q  <= 1'b0;
            timer_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            pending_q  <= pending_d;
            timer_q    <= timer_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mdone_q    <= mdone_d;
        end
    end

    // Message buffer is pure datapath: it is only read after a launch has loaded it.
    always_ff @(posedge clk) begin
        msg_q <= msg_d;
    end

    assign bus.UART_tx  = tx_q;
    assign bus.busy     = busy_q;
    assign bus.byte_idx = byte_idx_q;
    assign bus.tx_done  = done_q;
    assign bus.msg_done = mdone_q;
endmodule

// File: tb/tb_uart_msg_tx.sv
// Bench for uart_msg_tx: three configurations driven with fixed and random messages.
// Latency: n/a. Backpressure: n/a.
// Expected line/status per cycle comes from frame arithmetic (bit position = cycle / BAUD_DIV).
module tb_uart_msg_tx;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_msg_tx_if #(.MSG_LEN(3)) ia();
    uart_msg_tx_if #(.MSG_LEN(3)) ib();
    uart_msg_tx_if #(.MSG_LEN(1)) ic();

    // A: no parity, 1 stop, period 200
    uart_msg_tx #(.CLK_FREQ(40), .BAUD(10), .MSG_LEN(3), .PERIOD_CYC(200),
                  .PARITY(0), .STOP_BITS(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    // B: even parity, 2 stop
    uart_msg_tx #(.CLK_FREQ(40), .BAUD(10), .MSG_LEN(3), .PERIOD_CYC(1000),
                  .PARITY(1), .STOP_BITS(2)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
    // C: odd parity, 1 stop, period shorter than one message
    uart_msg_tx #(.CLK_FREQ(40), .BAUD(10), .MSG_LEN(1), .PERIOD_CYC(30),
                  .PARITY(2), .STOP_BITS(1)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

    int errors = 0;
    int checks = 0;
    int sel = 0;

    logic o_tx, o_busy, o_done, o_mdone;
    int   o_idx;

    always_comb begin
        o_tx = ia.UART_tx; o_busy = ia.busy; o_done = ia.tx_done; o_mdone = ia.msg_done;
        o_idx = int'(ia.byte_idx);
        if (sel == 1) begin
            o_tx = ib.UART_tx; o_busy = ib.busy; o_done = ib.tx_done; o_mdone = ib.msg_done;
            o_idx = int'(ib.byte_idx);
        end else if (sel == 2) begin
            o_tx = ic.UART_tx; o_busy = ic.busy; o_done = ic.tx_done; o_mdone = ic.msg_done;
            o_idx = int'(ic.byte_idx);
        end
    end

    task automatic set_start(input int s, input logic v);
        case (s)
            0:       ia.start = v;
            1:       ib.start = v;
            default: ic.start = v;
        endcase
    endtask

    // Returns in the first start-bit cycle of the launched message.
    task automatic pulse_start(input int s);
        @(posedge clk); #1 set_start(s, 1'b1);
        @(posedge clk); #1 set_start(s, 1'b0);
    endtask

    // Walks one whole message cycle by cycle, starting at the next falling edge.
    task automatic expect_msg(input string name, input int s, input int nb, input int par,
                              input int stops, input logic [7:0] m0, input logic [7:0] m1,
                              input logic [7:0] m2);
        logic [7:0]  m [3];
        logic [11:0] e, o;
        logic        ebit;
        int          flen, b, pos, bn;
        bit          bad;
        m[0] = m0; m[1] = m1; m[2] = m2;
        flen = DIV * (10 + ((par != 0) ? 1 : 0) + stops - 1);
        bad  = 1'b0;
        sel  = s;
        for (int i = 0; i < nb * flen && !bad; i++) begin
            b   = i / flen;
            pos = i % flen;
            bn  = pos / DIV;
            if (bn == 0)                  ebit = 1'b0;
            else if (bn <= 8)             ebit = m[b][bn-1];
            else if (bn == 9 && par != 0) ebit = (^m[b]) ^ (par == 2);
            else                          ebit = 1'b1;
            @(negedge clk);
            e = {ebit, 1'b1, pos == flen - 1, (pos == flen - 1) && (b == nb - 1), 8'(b)};
            o = {o_tx, o_busy, o_done, o_mdone, 8'(o_idx)};
            if (o !== e) begin
                $display("FAIL %s cycle %0d: tx,busy,done,mdone,idx got %b want %b", name, i, o, e);
                errors++;
                bad = 1'b1;
            end
        end
        checks++;
    endtask

    task automatic check_idle(input string name, input int s, input int n);
        logic [11:0] o;
        bit          bad;
        bad = 1'b0;
        sel = s;
        for (int i = 0; i < n && !bad; i++) begin
            @(negedge clk);
            o = {o_tx, o_busy, o_done, o_mdone, 8'(o_idx)};
            if (o !== 12'h800) begin
                $display("FAIL %s idle cycle %0d: tx,busy,done,mdone,idx got %b want %b",
                         name, i, o, 12'h800);
                errors++;
                bad = 1'b1;
            end
        end
        checks++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            @(negedge clk);
            if ({o_tx, o_busy, o_done, o_mdone, 8'(o_idx)} !== 12'h800) begin
                $display("FAIL reset_state dut%0d: got %b want %b", s,
                         {o_tx, o_busy, o_done, o_mdone, 8'(o_idx)}, 12'h800);
                errors++;
            end
            checks++;
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] d [3];
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin d[0] = 8'h55; d[1] = 8'hAA; d[2] = 8'h0F; end
            else for (int j = 0; j < 3; j++) d[j] = 8'($urandom);
            ia.msg_data = {d[2], d[1], d[0]};
            pulse_start(0);
            expect_msg("basic_msg", 0, 3, 0, 1, d[0], d[1], d[2]);
            check_idle("basic_after", 0, 6);
        end
    endtask

    task automatic test_frame_cfg();
        logic [7:0] d [3];
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin d[0] = "H"; d[1] = "E"; d[2] = "L"; end
            else for (int j = 0; j < 3; j++) d[j] = 8'($urandom);
            ib.msg_data = {d[2], d[1], d[0]};
            pulse_start(1);
            expect_msg("even_2stop_msg", 1, 3, 1, 2, d[0], d[1], d[2]);
            check_idle("even_2stop_after", 1, 6);
        end
        for (int k = 0; k < 3; k++) begin
            d[0] = (k == 0) ? 8'h07 : 8'($urandom);
            ic.msg_data = d[0];
            pulse_start(2);
            expect_msg("odd_msg", 2, 1, 2, 1, d[0], 8'h00, 8'h00);
            check_idle("odd_after", 2, 6);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] d1, d2;
        d1 = 24'($urandom);
        d2 = ~d1;
        ia.msg_data = d1;
        pulse_start(0);
        fork
            begin
                expect_msg("pend_first", 0, 3, 0, 1, d1[7:0], d1[15:8], d1[23:16]);
                expect_msg("pend_second", 0, 3, 0, 1, d2[7:0], d2[15:8], d2[23:16]);
            end
            begin
                repeat (20) @(posedge clk);
                #1 ia.msg_data = d2;
                for (int k = 0; k < 3; k++) begin
                    pulse_start(0);
                    repeat (8) @(posedge clk);
                end
            end
        join
        check_idle("pend_after", 0, 30);
    endtask

    task automatic test_auto();
        logic [23:0] d;
        d = 24'($urandom);
        ia.msg_data = d;
        @(posedge clk); #1 ia.auto_en = 1'b1;
        check_idle("auto_wait0", 0, 200);
        for (int k = 0; k < 3; k++) begin
            expect_msg("auto_msg", 0, 3, 0, 1, d[7:0], d[15:8], d[23:16]);
            check_idle("auto_gap", 0, (k == 2) ? 40 : 80);
        end
        @(posedge clk); #1 ia.auto_en = 1'b0;
        check_idle("auto_off", 0, 300);

        // Period shorter than a message: frames run back to back via the pending flag.
        ic.msg_data = 8'($urandom);
        @(posedge clk); #1 ic.auto_en = 1'b1;
        check_idle("auto_c_wait", 2, 30);
        for (int k = 0; k < 3; k++)
            expect_msg("auto_c_msg", 2, 1, 2, 1, ic.msg_data, 8'h00, 8'h00);
        fork
            begin @(posedge clk); #1 ic.auto_en = 1'b0; end
        join_none
        expect_msg("auto_c_last", 2, 1, 2, 1, ic.msg_data, 8'h00, 8'h00);
        check_idle("auto_c_off", 2, 100);
    endtask

    task automatic test_reset_mid();
        logic [23:0] d;
        d = 24'($urandom);
        ia.msg_data = d;
        sel = 0;
        pulse_start(0);
        repeat (20) @(negedge clk);
        pulse_start(0);                 // leaves a pending request that reset must drop
        repeat (30) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        if ({o_tx, o_busy, o_done, o_mdone, 8'(o_idx)} !== 12'h800) begin
            $display("FAIL reset_abort: got %b want %b",
                     {o_tx, o_busy, o_done, o_mdone, 8'(o_idx)}, 12'h800);
            errors++;
        end
        checks++;
        check_idle("reset_no_resume", 0, 150);
        pulse_start(0);
        expect_msg("after_reset_msg", 0, 3, 0, 1, d[7:0], d[15:8], d[23:16]);
    endtask

    initial begin
        ia.msg_data = '0; ia.start = 1'b0; ia.auto_en = 1'b0;
        ib.msg_data = '0; ib.start = 1'b0; ib.auto_en = 1'b0;
        ic.msg_data = '0; ic.start = 1'b0; ic.auto_en = 1'b0;
        test_reset();
        test_basic();
        test_frame_cfg();
        test_back_to_back();
        test_auto();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
